ram_arbiter: RTL and testbench

- Shares the single-port 1024 x 8 data RAM between two requesters: the CPU datapath (load/store, indexed memory) and the DMA engine (RX/TX buffer transfers).
- Grants one access per cycle and drives the RAM port from the winner.
- Arbitration is CPU-priority with two DMA exceptions: a bounded DMA burst lock, and a starvation guarantee.
- Sits between the CPU/DMA memory ports and the RAM instance.

---
 rtl/ram_arbiter_pkg.sv | 21 ++
 rtl/ram_arbiter.sv | 115 +++++++++++
 tb/tb_ram_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the data-RAM arbiter between the CPU and DMA ports.
// RAM geometry, owner encoding and a saturating-increment helper live here.
package ram_arbiter_pkg;

  localparam int RAM_DEPTH  = 1024;
  localparam int RAM_ADDR_W = $clog2(RAM_DEPTH);
  localparam int DATA_W     = 8;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } arb_owner_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                               input logic [CNT_W-1:0] limit);
    return (value >= limit) ? limit : value + 1'b1;
  endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: CPU priority with a bounded DMA burst lock and a
// DMA starvation guarantee. Grants are combinational, read valids are registered.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [RAM_ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_W-1:0]     cpu_rdata,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic                  dma_lock,
  input  logic [RAM_ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0]     dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [DATA_W-1:0]     dma_rdata,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata,
  output logic [1:0]            arb_owner
);

  localparam logic [CNT_W-1:0] WAIT_LIM  = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [CNT_W-1:0] burst_cnt_reg, burst_cnt_next;
  logic             cpu_rvalid_reg, dma_rvalid_reg;
  arb_owner_t       owner;
  logic             lock_active;

  // The lock only holds once a burst has started and until it reaches its cap.
  assign lock_active = dma_lock && (burst_cnt_reg != '0) && (burst_cnt_reg < BURST_LIM);

  always_comb begin
    owner = OWN_NONE;
    if (rst)
      owner = OWN_NONE;
    else if (dma_req && lock_active)
      owner = OWN_DMA;
    else if (dma_req && (wait_cnt_reg == WAIT_LIM))
      owner = OWN_DMA;
    else if (cpu_req)
      owner = OWN_CPU;
    else if (dma_req)
      owner = OWN_DMA;
  end

  assign cpu_gnt   = (owner == OWN_CPU);
  assign dma_gnt   = (owner == OWN_DMA);
  assign arb_owner = owner;

  always_comb begin
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (owner)
      OWN_CPU: begin
        ram_cs    = 1'b1;
        ram_we    = cpu_we;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
      end
      OWN_DMA: begin
        ram_cs    = 1'b1;
        ram_we    = dma_we;
        ram_addr  = dma_addr;
        ram_wdata = dma_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    wait_cnt_next  = '0;
    burst_cnt_next = '0;
    if (dma_req && !dma_gnt)
      wait_cnt_next = sat_inc(wait_cnt_reg, WAIT_LIM);
    if (dma_gnt && dma_lock)
      burst_cnt_next = sat_inc(burst_cnt_reg, BURST_LIM);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_reg   <= '0;
      burst_cnt_reg  <= '0;
      cpu_rvalid_reg <= 1'b0;
      dma_rvalid_reg <= 1'b0;
    end else begin
      wait_cnt_reg   <= wait_cnt_next;
      burst_cnt_reg  <= burst_cnt_next;
      cpu_rvalid_reg <= cpu_gnt && !cpu_we;
      dma_rvalid_reg <= dma_gnt && !dma_we;
    end
  end

  // Both requesters see the raw RAM output; rvalid tells each whose data it is.
  assign cpu_rvalid = cpu_rvalid_reg;
  assign dma_rvalid = dma_rvalid_reg;
  assign cpu_rdata  = ram_rdata;
  assign dma_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios then randomized traffic, each cycle
// checked against a rule-level reference model and a shadow memory.
module tb_ram_arbiter;

  localparam int MAX_WAIT  = 4;
  localparam int MAX_BURST = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic       dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
  logic [9:0] dma_addr;
  logic [7:0] dma_wdata, dma_rdata;
  logic       ram_cs, ram_we;
  logic [9:0] ram_addr;
  logic [7:0] ram_wdata, ram_rdata;
  logic [1:0] arb_owner;

  ram_arbiter #(.MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .arb_owner(arb_owner)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with one-cycle registered read.
  logic [7:0] ram_mem [1024];
  always @(posedge clk) begin
    if (ram_cs && ram_we) ram_mem[ram_addr] <= ram_wdata;
    if (ram_cs && !ram_we) ram_rdata <= ram_mem[ram_addr];
  end

  // Reference model state.
  logic [7:0] shadow [1024];
  int         refused_streak, locked_run;
  logic       exp_cpu_rv, exp_dma_rv;
  logic [7:0] exp_rdata;
  int         n_cmp, n_bad;
  int         obs_owner;
  logic       obs_cpu_rv, obs_dma_rv;
  logic [7:0] obs_rdata;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: inputs are already driven; check outputs, advance the model.
  task automatic tick();
    int win;
    logic crv, drv;
    #3;
    if (rst) win = 0;
    else if (dma_req && dma_lock && locked_run > 0 && locked_run < MAX_BURST) win = 2;
    else if (dma_req && refused_streak >= MAX_WAIT) win = 2;
    else if (cpu_req) win = 1;
    else if (dma_req) win = 2;
    else win = 0;
    crv = rst ? 1'b0 : exp_cpu_rv;
    drv = rst ? 1'b0 : exp_dma_rv;
    obs_owner  = int'(arb_owner);
    obs_cpu_rv = cpu_rvalid;
    obs_dma_rv = dma_rvalid;
    obs_rdata  = cpu_rdata;
    $display("t=%0t rst=%0d creq=%0d dreq=%0d lock=%0d owner=%0d ram_cs=%0d addr=%03h crv=%0d drv=%0d rdata=%02h",
             $time, rst, cpu_req, dma_req, dma_lock, arb_owner, ram_cs, ram_addr, cpu_rvalid, dma_rvalid, cpu_rdata);
    chk("arb_owner", 32'(arb_owner), 32'(win));
    chk("cpu_gnt", 32'(cpu_gnt), 32'(win == 1));
    chk("dma_gnt", 32'(dma_gnt), 32'(win == 2));
    chk("ram_cs", 32'(ram_cs), 32'(win != 0));
    chk("ram_we", 32'(ram_we), 32'(win == 1 ? cpu_we : win == 2 ? dma_we : 1'b0));
    if (win != 0 || rst) begin
      chk("ram_addr", 32'(ram_addr), 32'(win == 1 ? cpu_addr : win == 2 ? dma_addr : 10'd0));
      chk("ram_wdata", 32'(ram_wdata), 32'(win == 1 ? cpu_wdata : win == 2 ? dma_wdata : 8'd0));
    end
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(crv));
    chk("dma_rvalid", 32'(dma_rvalid), 32'(drv));
    if (crv) chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_rdata));
    if (drv) chk("dma_rdata", 32'(dma_rdata), 32'(exp_rdata));
    if (rst) begin
      refused_streak = 0;
      locked_run     = 0;
      exp_cpu_rv     = 1'b0;
      exp_dma_rv     = 1'b0;
    end else begin
      refused_streak = (dma_req && win != 2) ? ((refused_streak + 1 > MAX_WAIT) ? MAX_WAIT : refused_streak + 1) : 0;
      locked_run     = (win == 2 && dma_lock) ? ((locked_run + 1 > MAX_BURST) ? MAX_BURST : locked_run + 1) : 0;
      exp_cpu_rv     = (win == 1) && !cpu_we;
      exp_dma_rv     = (win == 2) && !dma_we;
      if (win == 1) begin
        if (cpu_we) shadow[cpu_addr] = cpu_wdata; else exp_rdata = shadow[cpu_addr];
      end else if (win == 2) begin
        if (dma_we) shadow[dma_addr] = dma_wdata; else exp_rdata = shadow[dma_addr];
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    refused_streak = 0; locked_run = 0;
    exp_cpu_rv = 1'b0; exp_dma_rv = 1'b0; exp_rdata = 8'h00;
    for (int i = 0; i < 1024; i++) begin
      ram_mem[i] = 8'h00;
      shadow[i]  = 8'h00;
    end
    ram_rdata = 8'h00;

    // Reset with requests present: everything forced idle.
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h155; cpu_wdata = 8'hAA;
    dma_req = 1'b1; dma_we = 1'b1; dma_lock = 1'b1; dma_addr = 10'h2AA; dma_wdata = 8'h55;
    tick();
    tick();
    rst = 1'b0; cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_owner", 32'(obs_owner), 32'd0);
    end

    // CPU write then read back.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h040; cpu_wdata = 8'h3A;
    tick();
    chk("cpu_wr_owner", 32'(obs_owner), 32'd1);
    cpu_we = 1'b0;
    tick();
    chk("cpu_rd_owner", 32'(obs_owner), 32'd1);
    cpu_req = 1'b0;
    tick();
    chk("cpu_rd_valid", 32'(obs_cpu_rv), 32'd1);
    chk("cpu_rd_data", 32'(obs_rdata), 32'h3A);
    chk("cpu_rd_dma_rv", 32'(obs_dma_rv), 32'd0);

    // Continuous contention without lock: CPU x MAX_WAIT, then DMA.
    cpu_req = 1'b1; cpu_we = 1'b0; dma_req = 1'b1; dma_we = 1'b0; dma_lock = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cpu_addr = 10'(i); dma_addr = 10'(100 + i);
      tick();
      chk("starve_pattern", 32'(obs_owner), (i % 5 == 4) ? 32'd2 : 32'd1);
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    tick();

    // Locked DMA burst started while CPU idle, CPU then waits MAX_BURST grants.
    dma_req = 1'b1; dma_lock = 1'b1; dma_we = 1'b1; dma_wdata = 8'hC3;
    for (int i = 0; i <= MAX_BURST; i++) begin
      dma_addr = 10'(200 + i);
      tick();
      chk("burst_pattern", 32'(obs_owner), (i < MAX_BURST) ? 32'd2 : 32'd1);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h201;
    end
    cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;
    tick();

    // Simultaneous CPU read vs DMA write with no accumulated wait.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 10'h011; dma_wdata = 8'h77;
    tick();
    chk("simul_cpu_first", 32'(obs_owner), 32'd1);
    cpu_req = 1'b0;
    tick();
    chk("simul_dma_next", 32'(obs_owner), 32'd2);
    chk("simul_cpu_rv", 32'(obs_cpu_rv), 32'd1);
    dma_req = 1'b0;
    tick();

    // Reset right after a locked DMA read grant drops the read.
    dma_req = 1'b1; dma_we = 1'b0; dma_lock = 1'b1; dma_addr = 10'h200;
    tick();
    chk("rst_dma_gnt", 32'(obs_owner), 32'd2);
    rst = 1'b1; dma_req = 1'b0; dma_lock = 1'b0;
    tick();
    chk("rst_dma_rv", 32'(obs_dma_rv), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_wait_cnt", 32'(dut.wait_cnt_reg), 32'd0);
    chk("rst_burst_cnt", 32'(dut.burst_cnt_reg), 32'd0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h011;
    dma_req = 1'b1; dma_we = 1'b0; dma_lock = 1'b1; dma_addr = 10'h012;
    tick();
    chk("post_rst_cpu_prio", 32'(obs_owner), 32'd1);
    chk("post_rst_dma_rv", 32'(obs_dma_rv), 32'd0);

    // Randomized traffic; requesters hold their request until granted.
    for (int i = 0; i < 3000; i++) begin
      logic cg, dg;
      rst = ($urandom_range(0, 199) == 0);
      dma_lock = ($urandom_range(0, 3) != 0);
      tick();
      cg = (obs_owner == 1);
      dg = (obs_owner == 2);
      if (cg || !cpu_req) begin
        cpu_req = ($urandom_range(0, 3) != 0); cpu_we = $urandom_range(0, 1) == 1;
        cpu_addr = 10'($urandom_range(0, 31)); cpu_wdata = 8'($urandom);
      end
      if (dg || !dma_req) begin
        dma_req = ($urandom_range(0, 3) != 0); dma_we = $urandom_range(0, 1) == 1;
        dma_addr = 10'($urandom_range(0, 31)); dma_wdata = 8'($urandom);
      end
    end
    rst = 1'b0; cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
